// File: rtl/module_abc.sv
// Modulo-N counter with a prescaled step strobe and a two-flop reset release synchronizer.
// Define MODULE_ABC_DOWN_EN to build a down-counter instead of the default up-counter.
module module_abc #(
   parameter int MODULO   = 10,
   parameter int PRESCALE = 1
) (
   input  logic       clk,
   input  logic       rst,
   output logic [5:0] count_o
);

   localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [5:0]     CNT_LAST = 6'(MODULO - 1);

   generate
      if (MODULO < 2 || MODULO > 64 || PRESCALE < 1 || PRESCALE > 256) begin : g_bad_param
         $fatal(1, "module_abc: MODULO must be 2..64 and PRESCALE 1..256");
      end
   endgenerate

   logic [1:0]    rst_sync_q, rst_sync_d;
   logic [PW-1:0] pre_q, pre_d;
   logic [5:0]    count_q, count_d;
   logic          run;
   logic          step;

   always_comb begin
      rst_sync_d = {rst_sync_q[0], 1'b1};
      run        = rst_sync_q[1];
      step       = run && (pre_q == PRE_LAST);

      pre_d = pre_q;
      if (run) begin
         pre_d = step ? '0 : pre_q + PW'(1);
      end

      count_d = count_q;
      if (step) begin
`ifdef MODULE_ABC_DOWN_EN
         count_d = (count_q == 6'd0) ? CNT_LAST : count_q - 6'd1;
`else
         // With MODULO=64 the compare hits 63 and wraps to 0 like a plain 6-bit counter.
         count_d = (count_q == CNT_LAST) ? 6'd0 : count_q + 6'd1;
`endif
      end
   end

   // Assertion clears everything at once; release only propagates through rst_sync_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync_q <= 2'b00;
         pre_q      <= '0;
         count_q    <= 6'd0;
      end else begin
         rst_sync_q <= rst_sync_d;
         pre_q      <= pre_d;
         count_q    <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: tb/tb_module_abc.sv
// Self-checking bench for module_abc: four parameterisations against an edge-count model.
module tb_module_abc;

   logic       clk = 1'b1;
   logic       rst = 1'b0;
   logic [5:0] cnt_a, cnt_b, cnt_c, cnt_d;

   int total = 0;
   int bad   = 0;

   // Rising edges seen with reset high since the last reset assertion.
   int n_edges = 0;

   localparam int NDUT = 4;
   int mod_t [NDUT] = '{10, 10, 64, 2};
   int pre_t [NDUT] = '{1, 4, 1, 3};
   string name_t [NDUT] = '{"m10p1", "m10p4", "m64p1", "m2p3"};

`ifdef MODULE_ABC_DOWN_EN
   int lit_a [13] = '{0, 0, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
   localparam int LIT_B41 = 1;
   localparam int LIT_C3  = 63;
   localparam int LIT_C65 = 1;
`else
   int lit_a [13] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1};
   localparam int LIT_B41 = 9;
   localparam int LIT_C3  = 1;
   localparam int LIT_C65 = 63;
`endif

   module_abc #(.MODULO(10), .PRESCALE(1)) u_a (.clk(clk), .rst(rst), .count_o(cnt_a));
   module_abc #(.MODULO(10), .PRESCALE(4)) u_b (.clk(clk), .rst(rst), .count_o(cnt_b));
   module_abc #(.MODULO(64), .PRESCALE(1)) u_c (.clk(clk), .rst(rst), .count_o(cnt_c));
   module_abc #(.MODULO(2),  .PRESCALE(3)) u_d (.clk(clk), .rst(rst), .count_o(cnt_d));

   always #10 clk = ~clk;

   function automatic logic [5:0] dut_cnt(int i);
      case (i)
         0:       return cnt_a;
         1:       return cnt_b;
         2:       return cnt_c;
         default: return cnt_d;
      endcase
   endfunction

   // Two edges of release latency, then one step every p edges.
   function automatic int model_cnt(int n, int m, int p);
      int s;
      s = (n >= 2) ? (n - 2) / p : 0;
`ifdef MODULE_ABC_DOWN_EN
      return (m - (s % m)) % m;
`else
      return s % m;
`endif
   endfunction

   task automatic check(string what, logic [5:0] act, int exp, int m);
      total++;
      if ($isunknown(act) || int'(act) != exp || int'(act) >= m) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (modulo %0d) at %0t", what, act, exp, m, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) n_edges = 0;
      else      n_edges = n_edges + 1;
   end

   always @(negedge clk) begin
      for (int i = 0; i < NDUT; i++) begin
         check({name_t[i], " model"}, dut_cnt(i), model_cnt(n_edges, mod_t[i], pre_t[i]), mod_t[i]);
      end
   end

   task automatic check_all_zero(string what);
      for (int i = 0; i < NDUT; i++) begin
         check({name_t[i], " ", what}, dut_cnt(i), 0, mod_t[i]);
      end
   endtask

   initial begin
      #29;
      check_all_zero("in reset");
      #1;
      rst = 1'b1;
      for (int e = 1; e <= 70; e++) begin
         @(posedge clk);
         #1;
         if (e <= 13) check($sformatf("m10p1 lit e%0d", e), cnt_a, lit_a[e-1], 10);
         if (e == 5)  check("m10p4 lit e5", cnt_b, 0, 10);
         if (e == 6)  check("m10p4 lit e6", cnt_b, (LIT_C3 == 1) ? 1 : 9, 10);
         if (e == 41) check("m10p4 lit e41", cnt_b, LIT_B41, 10);
         if (e == 42) check("m10p4 lit e42", cnt_b, 0, 10);
         if (e == 3)  check("m64p1 lit e3", cnt_c, LIT_C3, 64);
         if (e == 65) check("m64p1 lit e65", cnt_c, LIT_C65, 64);
         if (e == 66) check("m64p1 lit e66", cnt_c, 0, 64);
      end

      begin : mid_count
         bit found;
         found = 1'b0;
         for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #3;
            if (cnt_a == 6'd6) found = 1'b1;
         end
         total++;
         if (!found) begin
            bad++;
            $display("FAIL mid-count wait: m10p1 never showed 6, last %0d", cnt_a);
         end
         rst = 1'b0;
         #1;
         check_all_zero("mid-count reset");
         repeat ($urandom_range(1, 4)) @(posedge clk);
         #5;
         rst = 1'b1;
      end

      for (int it = 0; it < 20; it++) begin
         repeat ((it % 5 == 4) ? $urandom_range(200, 600) : $urandom_range(3, 120)) @(posedge clk);
         #($urandom_range(2, 8));
         rst = 1'b0;
         #1;
         check_all_zero("async reset");
         repeat ($urandom_range(0, 4)) @(posedge clk);
         @(posedge clk);
         #($urandom_range(2, 8));
         rst = 1'b1;
      end
      repeat (80) @(posedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

endmodule
